// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the RV32 pipeline hazard logic: operand-forward selects
// and the hazard controller state type.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_WBA = 2'b10;
  localparam logic [1:0] FWD_WBM = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH,
    ST_WAIT
  } hz_state_t;

endpackage

// File: rtl/hz_src_match.sv
// Per-operand RAW hazard decode: compares one ID source against the EX/MEM/WB
// producers and picks the youngest match.
module hz_src_match
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_use,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr,
  input  logic              ex_ld,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wr,
  input  logic              mem_ld,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wr,
  output logic [1:0]        sel,
  output logic              byp,
  output logic              load_use,
  output logic              hazard
);

  logic m_ex, m_mem, m_wb;

  assign m_ex  = rs_use && ex_wr  && (ex_rd  != '0) && (ex_rd  == rs);
  assign m_mem = rs_use && mem_wr && (mem_rd != '0) && (mem_rd == rs);
  assign m_wb  = rs_use && wb_wr  && (wb_rd  != '0) && (wb_rd  == rs);

  // Without forwarding, any in-flight producer ahead of WB must be waited out.
  always_comb begin
    sel      = FWD_RF;
    byp      = 1'b0;
    load_use = 1'b0;
    hazard   = 1'b0;
    if (m_ex) begin
      if (FWD_EN != 0) begin
        sel      = FWD_EXM;
        load_use = ex_ld;
      end else begin
        hazard = 1'b1;
      end
    end else if (m_mem) begin
      if (FWD_EN != 0) sel = mem_ld ? FWD_WBM : FWD_WBA;
      else hazard = 1'b1;
    end else if (m_wb) begin
      byp = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit_v4.sv
// Unified hazard controller: forward-select registers, stall/flush/freeze FSM
// and saturating stall/flush performance counters.
//
// state    | meaning
// ST_RUN   | normal issue; acts on freeze, taken branch or hazard this cycle
// ST_STALL | multi-cycle load-use bubble, seq_cnt cycles remaining
// ST_FLUSH | late-redirect flush after a taken branch, seq_cnt cycles remaining
// ST_WAIT  | data memory busy; saved_state resumes when dmem_ready returns
module hazard_control_unit_v4
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int BR_EXTRA   = 0,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr,
  input  logic              ex_ld,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wr,
  input  logic              mem_ld,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wr,
  input  logic              br_taken,
  input  logic              dmem_ready,
  output logic [1:0]        rs1_src,
  output logic [1:0]        rs2_src,
  output logic              rf_byp1,
  output logic              rf_byp2,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              freeze,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int CNT_MAX = (LOAD_STALL > BR_EXTRA) ? LOAD_STALL : BR_EXTRA;
  localparam int SW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  hz_state_t     state, state_nx, saved_state, saved_nx, eff_state;
  logic [SW-1:0] seq_cnt, cnt_nx;
  logic [1:0]    sel1, sel2;
  logic          byp1, byp2, lu1, lu2, hz1, hz2, hazard, take_br;

  hz_src_match #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_match1 (
    .rs(id_rs1), .rs_use(id_use1),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_ld(ex_ld),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ld(mem_ld),
    .wb_rd(wb_rd), .wb_wr(wb_wr),
    .sel(sel1), .byp(byp1), .load_use(lu1), .hazard(hz1)
  );

  hz_src_match #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_match2 (
    .rs(id_rs2), .rs_use(id_use2),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_ld(ex_ld),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ld(mem_ld),
    .wb_rd(wb_rd), .wb_wr(wb_wr),
    .sel(sel2), .byp(byp2), .load_use(lu2), .hazard(hz2)
  );

  assign hazard = lu1 | lu2 | hz1 | hz2;

  // The cycle dmem_ready returns, the pipe moves again under the saved state.
  assign eff_state = (state == ST_WAIT) ? saved_state : state;
  assign take_br   = dmem_ready && br_taken &&
                     ((eff_state == ST_RUN) || (eff_state == ST_STALL));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      saved_state <= ST_RUN;
      seq_cnt     <= '0;
    end else begin
      state       <= state_nx;
      saved_state <= saved_nx;
      seq_cnt     <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    saved_nx    = saved_state;
    cnt_nx      = seq_cnt;
    pc_hold     = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    freeze      = 1'b0;
    if (!dmem_ready) begin
      freeze = 1'b1;
      if (state != ST_WAIT) begin
        saved_nx = state;
        state_nx = ST_WAIT;
      end
    end else if (take_br) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      if (BR_EXTRA > 0) begin
        state_nx = ST_FLUSH;
        cnt_nx   = SW'(BR_EXTRA);
      end else begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end
    end else begin
      state_nx = eff_state;
      case (eff_state)
        ST_RUN: begin
          if (hazard) begin
            pc_hold     = 1'b1;
            idex_bubble = 1'b1;
            if (LOAD_STALL > 1) begin
              state_nx = ST_STALL;
              cnt_nx   = SW'(LOAD_STALL - 1);
            end
          end
        end
        ST_STALL: begin
          pc_hold     = 1'b1;
          idex_bubble = 1'b1;
          if (seq_cnt == SW'(1)) begin
            state_nx = ST_RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = seq_cnt - 1'b1;
          end
        end
        ST_FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (seq_cnt == SW'(1)) begin
            state_nx = ST_RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = seq_cnt - 1'b1;
          end
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

  assign ifid_hold = pc_hold;
  assign rf_byp1   = byp1 & ~freeze;
  assign rf_byp2   = byp2 & ~freeze;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_src <= FWD_RF;
      rs2_src <= FWD_RF;
    end else if (!freeze) begin
      if (idex_bubble || idex_flush) begin
        rs1_src <= FWD_RF;
        rs2_src <= FWD_RF;
      end else begin
        rs1_src <= sel1;
        rs2_src <= sel2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((pc_hold || freeze) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (take_br && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit_v4.sv
// Directed bench: a vector table on the default configuration plus hand
// sequences on a LOAD_STALL=3 / BR_EXTRA=2 / CNT_W=4 instance.
module tb_hazard_control_unit_v4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use1, id_use2, ex_wr, ex_ld, mem_wr, mem_ld, wb_wr, br_taken, dmem_ready;

  logic [1:0]  d1_rs1_src, d1_rs2_src, d2_rs1_src, d2_rs2_src;
  logic        d1_byp1, d1_byp2, d1_pc_hold, d1_ifid_hold, d1_bubble, d1_ifid_flush, d1_idex_flush, d1_freeze;
  logic        d2_byp1, d2_byp2, d2_pc_hold, d2_ifid_hold, d2_bubble, d2_ifid_flush, d2_idex_flush, d2_freeze;
  logic [15:0] d1_stall_cnt, d1_flush_cnt;
  logic [3:0]  d2_stall_cnt, d2_flush_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_control_unit_v4 dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_ld(ex_ld),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ld(mem_ld),
    .wb_rd(wb_rd), .wb_wr(wb_wr), .br_taken(br_taken), .dmem_ready(dmem_ready),
    .rs1_src(d1_rs1_src), .rs2_src(d1_rs2_src), .rf_byp1(d1_byp1), .rf_byp2(d1_byp2),
    .pc_hold(d1_pc_hold), .ifid_hold(d1_ifid_hold), .idex_bubble(d1_bubble),
    .ifid_flush(d1_ifid_flush), .idex_flush(d1_idex_flush), .freeze(d1_freeze),
    .stall_cnt(d1_stall_cnt), .flush_cnt(d1_flush_cnt)
  );

  hazard_control_unit_v4 #(.LOAD_STALL(3), .BR_EXTRA(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_ld(ex_ld),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ld(mem_ld),
    .wb_rd(wb_rd), .wb_wr(wb_wr), .br_taken(br_taken), .dmem_ready(dmem_ready),
    .rs1_src(d2_rs1_src), .rs2_src(d2_rs2_src), .rf_byp1(d2_byp1), .rf_byp2(d2_byp2),
    .pc_hold(d2_pc_hold), .ifid_hold(d2_ifid_hold), .idex_bubble(d2_bubble),
    .ifid_flush(d2_ifid_flush), .idex_flush(d2_idex_flush), .freeze(d2_freeze),
    .stall_cnt(d2_stall_cnt), .flush_cnt(d2_flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
    logic       u1, u2, ex_wr, ex_ld, mem_wr, mem_ld, wb_wr, br, rdy;
    logic       e_hold, e_flush, e_frz, e_byp1, e_byp2;
    logic [1:0] e_src1, e_src2;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
    input logic [4:0] exrd, input logic exwr, input logic exld,
    input logic [4:0] memrd, input logic memwr, input logic memld,
    input logic [4:0] wbrd, input logic wbwr, input logic br, input logic rdy,
    input logic hold, input logic fl, input logic frz, input logic b1, input logic b2,
    input logic [1:0] s1, input logic [1:0] s2);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.ex_rd = exrd; v.ex_wr = exwr; v.ex_ld = exld;
    v.mem_rd = memrd; v.mem_wr = memwr; v.mem_ld = memld;
    v.wb_rd = wbrd; v.wb_wr = wbwr; v.br = br; v.rdy = rdy;
    v.e_hold = hold; v.e_flush = fl; v.e_frz = frz; v.e_byp1 = b1; v.e_byp2 = b2;
    v.e_src1 = s1; v.e_src2 = s2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use1 = 0; id_use2 = 0;
    ex_rd = '0; ex_wr = 0; ex_ld = 0; mem_rd = '0; mem_wr = 0; mem_ld = 0;
    wb_rd = '0; wb_wr = 0; br_taken = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic lw_use();
    ex_rd = 5'd6; ex_wr = 1; ex_ld = 1; id_rs2 = 5'd6; id_use2 = 1;
  endtask

  int exp_stall;
  int exp_flush;

  initial begin
    idle();
    vecs[0]  = mk(1,1,2,1, 0,0,0, 0,0,0, 0,0, 0,1, 0,0,0,0,0, 0,0);
    vecs[1]  = mk(5,1,2,1, 5,1,0, 0,0,0, 0,0, 0,1, 0,0,0,0,0, 1,0);
    vecs[2]  = mk(1,1,6,1, 0,0,0, 6,1,0, 0,0, 0,1, 0,0,0,0,0, 0,2);
    vecs[3]  = mk(1,1,6,1, 0,0,0, 6,1,1, 0,0, 0,1, 0,0,0,0,0, 0,3);
    vecs[4]  = mk(3,1,2,1, 3,1,0, 3,1,1, 3,1, 0,1, 0,0,0,0,0, 1,0);
    vecs[5]  = mk(0,1,7,1, 0,1,0, 0,0,0, 7,1, 0,1, 0,0,0,0,1, 0,0);
    vecs[6]  = mk(4,0,2,1, 4,1,0, 0,0,0, 0,0, 0,1, 0,0,0,0,0, 0,0);
    vecs[7]  = mk(4,1,2,1, 4,0,0, 0,0,0, 0,0, 0,1, 0,0,0,0,0, 0,0);
    vecs[8]  = mk(1,1,6,1, 6,1,1, 0,0,0, 0,0, 0,1, 1,0,0,0,0, 0,0);
    vecs[9]  = mk(1,1,6,1, 0,0,0, 6,1,1, 0,0, 0,1, 0,0,0,0,0, 0,3);
    vecs[10] = mk(5,1,2,1, 5,1,0, 0,0,0, 0,0, 0,1, 0,0,0,0,0, 1,0);
    vecs[11] = mk(5,1,2,1, 0,0,0, 2,1,0, 0,0, 1,0, 0,0,1,0,0, 1,0);
    vecs[12] = mk(5,1,2,1, 0,0,0, 2,1,0, 0,0, 1,0, 0,0,1,0,0, 1,0);
    vecs[13] = mk(1,1,6,1, 6,1,1, 0,0,0, 0,0, 1,1, 0,1,0,0,0, 0,0);
    vecs[14] = mk(9,1,2,1, 0,0,0, 9,1,0, 9,1, 0,1, 0,0,0,0,0, 2,0);

    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("reset rs1_src", d1_rs1_src, 0);
    chk("reset rs2_src", d1_rs2_src, 0);
    chk("reset stall_cnt", d1_stall_cnt, 0);
    chk("reset flush_cnt", d1_flush_cnt, 0);
    chk("reset pc_hold", d1_pc_hold, 0);
    chk("reset freeze", d1_freeze, 0);

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      id_rs1 = vecs[i].rs1; id_use1 = vecs[i].u1; id_rs2 = vecs[i].rs2; id_use2 = vecs[i].u2;
      ex_rd = vecs[i].ex_rd; ex_wr = vecs[i].ex_wr; ex_ld = vecs[i].ex_ld;
      mem_rd = vecs[i].mem_rd; mem_wr = vecs[i].mem_wr; mem_ld = vecs[i].mem_ld;
      wb_rd = vecs[i].wb_rd; wb_wr = vecs[i].wb_wr;
      br_taken = vecs[i].br; dmem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d pc_hold", i), d1_pc_hold, vecs[i].e_hold);
      chk($sformatf("v%0d ifid_hold", i), d1_ifid_hold, vecs[i].e_hold);
      chk($sformatf("v%0d idex_bubble", i), d1_bubble, vecs[i].e_hold);
      chk($sformatf("v%0d ifid_flush", i), d1_ifid_flush, vecs[i].e_flush);
      chk($sformatf("v%0d idex_flush", i), d1_idex_flush, vecs[i].e_flush);
      chk($sformatf("v%0d freeze", i), d1_freeze, vecs[i].e_frz);
      chk($sformatf("v%0d rf_byp1", i), d1_byp1, vecs[i].e_byp1);
      chk($sformatf("v%0d rf_byp2", i), d1_byp2, vecs[i].e_byp2);
      if (vecs[i].e_hold || vecs[i].e_frz) exp_stall++;
      if (vecs[i].e_flush) exp_flush++;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rs1_src", i), d1_rs1_src, vecs[i].e_src1);
      chk($sformatf("v%0d rs2_src", i), d1_rs2_src, vecs[i].e_src2);
    end
    chk("table stall_cnt", d1_stall_cnt, exp_stall);
    chk("table flush_cnt", d1_flush_cnt, exp_flush);

    // Load-use with 3 bubbles interrupted by a taken branch, then 2 late-flush cycles.
    do_reset();
    lw_use();
    #1;
    chk("ls3 c1 pc_hold", d2_pc_hold, 1);
    chk("ls3 c1 idex_bubble", d2_bubble, 1);
    @(negedge clk);
    br_taken = 1;
    #1;
    chk("ls3 c2 ifid_flush", d2_ifid_flush, 1);
    chk("ls3 c2 idex_flush", d2_idex_flush, 1);
    chk("ls3 c2 pc_hold", d2_pc_hold, 0);
    @(negedge clk);
    idle();
    br_taken = 1;
    #1;
    chk("ls3 c3 idex_flush", d2_idex_flush, 1);
    chk("ls3 c3 pc_hold", d2_pc_hold, 0);
    @(negedge clk);
    br_taken = 0;
    #1;
    chk("ls3 c4 ifid_flush", d2_ifid_flush, 1);
    @(negedge clk);
    #1;
    chk("ls3 c5 ifid_flush", d2_ifid_flush, 0);
    chk("ls3 flush_cnt", d2_flush_cnt, 1);
    chk("ls3 stall_cnt", d2_stall_cnt, 1);

    // Memory wait inside a stall: count resumes where it left off.
    do_reset();
    lw_use();
    #1;
    chk("wait c1 pc_hold", d2_pc_hold, 1);
    @(negedge clk);
    #1;
    chk("wait c2 pc_hold", d2_pc_hold, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dmem_ready = 0;
      #1;
      chk($sformatf("wait f%0d freeze", k), d2_freeze, 1);
      chk($sformatf("wait f%0d pc_hold", k), d2_pc_hold, 0);
      chk($sformatf("wait f%0d rs2_src", k), d2_rs2_src, 0);
    end
    @(negedge clk);
    dmem_ready = 1;
    #1;
    chk("wait resume pc_hold", d2_pc_hold, 1);
    chk("wait resume freeze", d2_freeze, 0);
    @(negedge clk);
    idle();
    #1;
    chk("wait end pc_hold", d2_pc_hold, 0);
    chk("wait stall_cnt", d2_stall_cnt, 7);

    // Async reset in the middle of a late flush, then counter saturation.
    do_reset();
    br_taken = 1;
    #1;
    chk("rst c1 idex_flush", d2_idex_flush, 1);
    @(negedge clk);
    br_taken = 0;
    #1;
    chk("rst c2 idex_flush", d2_idex_flush, 1);
    #1;
    reset = 0;
    #1;
    chk("rst async idex_flush", d2_idex_flush, 0);
    chk("rst async ifid_flush", d2_ifid_flush, 0);
    chk("rst async flush_cnt", d2_flush_cnt, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1;
    chk("rst after idex_flush", d2_idex_flush, 0);
    dmem_ready = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    dmem_ready = 1;
    #1;
    chk("sat cnt4 stall_cnt", d2_stall_cnt, 15);
    chk("sat cnt16 stall_cnt", d1_stall_cnt, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
